// File: rtl/coproc_pio_engine.sv
// ---------------------------------------------------------------------------
// coproc_pio_engine
//   Compute engine that sits behind the coprocessor data PIOs. Software writes
//   operand A, operand B and a command byte. The engine then runs a
//   multi-cycle unsigned multiply (shift-add) or divide (restoring). It returns
//   the 64-bit result and a status word. Software polls these through the PIO
//   in_ports.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      synchronous, active-high reset
//   ctrl_in    in   8      [0] start toggle, [2:1] opcode (00 MULU, 01 DIVU,
//                          1x illegal), [7] irq ack (IRQ build only)
//   operand_a  in   WIDTH  operand A (data_high PIO out_port)
//   operand_b  in   WIDTH  operand B (data_low PIO out_port)
//   result_hi  out  WIDTH  product upper word / remainder
//   result_lo  out  WIDTH  product lower word / quotient
//   status     out  32     {16'b0, op_count[7:0], 3'b0, overrun,
//                           illegal_op, div_by_zero, done_tgl, busy}
//   irq        out  1      completion interrupt (IRQ build only)
//
// Build option
//   COPROC_ENGINE_IRQ_EN : adds the irq output. irq is set on completion and
//                          cleared by ctrl_in[7].
//
// States
//   IDLE   | waiting for ctrl_in[0] to differ from the accepted toggle
//   RUN    | one multiply/divide iteration per cycle, WIDTH cycles
//   FINISH | publish results, clear busy, advance done toggle and op count
// ---------------------------------------------------------------------------
module coproc_pio_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       ctrl_in,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
`ifdef COPROC_ENGINE_IRQ_EN
    output logic [31:0]      status,
    output logic             irq
`else
    output logic [31:0]      status
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             acc_tgl_q, acc_tgl_d;
    logic             done_tgl_q, done_tgl_d;
    logic             busy_q, busy_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CW-1:0]    iter_q, iter_d;
    logic             is_div_q, is_div_d;
    // Multiplicand for MULU, divisor for DIVU.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // MULU: {hi,lo} is the running product, with the multiplier shifting out
    // of lo. DIVU: hi is the partial remainder, lo is the dividend shifting
    // out while the quotient shifts in.
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;

    logic             start_pend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

`ifdef COPROC_ENGINE_IRQ_EN
    logic irq_q, irq_d;
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_in[6:3];
`else
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_in[7:3];
`endif

    assign start_pend = (ctrl_in[0] != acc_tgl_q);

    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    always_comb begin
        state_d    = state_q;
        acc_tgl_d  = acc_tgl_q;
        done_tgl_d = done_tgl_q;
        busy_d     = busy_q;
        dbz_d      = dbz_q;
        ill_d      = ill_q;
        ovr_d      = ovr_q;
        cnt_d      = cnt_q;
        iter_d     = iter_q;
        is_div_d   = is_div_q;
        opnd_d     = opnd_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;

        // A toggle that arrives while an op is in flight is not accepted here.
        // It is picked up in IDLE once the op completes.
        if (state_q != ST_IDLE && start_pend) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_pend) begin
                    acc_tgl_d = ctrl_in[0];
                    busy_d    = 1'b1;
                    dbz_d     = 1'b0;
                    ill_d     = 1'b0;
                    is_div_d  = ctrl_in[1];
                    if (ctrl_in[2]) begin
                        ill_d     = 1'b1;
                        work_hi_d = '0;
                        work_lo_d = '0;
                        state_d   = ST_FINISH;
                    end else if (ctrl_in[1] && (operand_b == '0)) begin
                        dbz_d     = 1'b1;
                        work_hi_d = operand_a;
                        work_lo_d = '1;
                        state_d   = ST_FINISH;
                    end else begin
                        opnd_d    = ctrl_in[1] ? operand_b : operand_a;
                        work_hi_d = '0;
                        work_lo_d = ctrl_in[1] ? operand_a : operand_b;
                        iter_d    = CW'(WIDTH);
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        work_hi_d = div_diff[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi_d = div_shift[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    work_hi_d = mul_sum[WIDTH:1];
                    work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                end
                iter_d = iter_q - 1'b1;
                if (iter_q == CW'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                res_hi_d   = work_hi_q;
                res_lo_d   = work_lo_q;
                busy_d     = 1'b0;
                done_tgl_d = acc_tgl_q;
                cnt_d      = cnt_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef COPROC_ENGINE_IRQ_EN
    // Completion takes priority over an acknowledge on the same edge.
    always_comb begin
        irq_d = irq_q;
        if (state_q == ST_FINISH) begin
            irq_d = 1'b1;
        end else if (ctrl_in[7]) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_tgl_q  <= 1'b0;
            done_tgl_q <= 1'b0;
            busy_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ill_q      <= 1'b0;
            ovr_q      <= 1'b0;
            cnt_q      <= '0;
            iter_q     <= '0;
            is_div_q   <= 1'b0;
            opnd_q     <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_tgl_q  <= acc_tgl_d;
            done_tgl_q <= done_tgl_d;
            busy_q     <= busy_d;
            dbz_q      <= dbz_d;
            ill_q      <= ill_d;
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
            iter_q     <= iter_d;
            is_div_q   <= is_div_d;
            opnd_q     <= opnd_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
        end
    end

    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign status    = {16'h0000, cnt_q, 3'b000, ovr_q, ill_q, dbz_q, done_tgl_q, busy_q};

endmodule

// File: tb/tb_coproc_pio_engine.sv
// ---------------------------------------------------------------------------
// Directed bench for coproc_pio_engine (WIDTH=32). Each started op pushes its
// expected result, latency and status onto a scoreboard queue. The entry is
// popped and compared when the engine reports completion.
// ---------------------------------------------------------------------------
module tb_coproc_pio_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ctrl_in;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic [31:0] status;
`ifdef COPROC_ENGINE_IRQ_EN
    logic        irq;
`endif

    coproc_pio_engine #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl_in   (ctrl_in),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result_hi (result_hi),
        .result_lo (result_lo),
`ifdef COPROC_ENGINE_IRQ_EN
        .status    (status),
        .irq       (irq)
`else
        .status    (status)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        ill;
        logic        done;
        logic [7:0]  cnt;
        int          k;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        tgl      = 1'b0;
    logic [7:0]  model_cnt = 8'd0;
    logic [7:0]  cnt_snap;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input int k);
        exp_t        e;
        logic [63:0] p;
        e.dbz = 1'b0;
        e.ill = 1'b0;
        e.lat = 33;
        if (op[1]) begin
            e.hi = '0; e.lo = '0; e.ill = 1'b1; e.lat = 1;
        end else if (op[0] && b == 0) begin
            e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
        end else if (op[0]) begin
            e.hi = a % b; e.lo = a / b;
        end else begin
            p = 64'(a) * 64'(b);
            e.hi = p[63:32]; e.lo = p[31:0];
        end
        model_cnt = model_cnt + 8'd1;
        e.cnt  = model_cnt;
        e.done = tgl;
        e.k    = k;
        sb.push_back(e);
    endtask

    // Drives a new command; the next rising edge is edge k unless overridden.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input int k);
        operand_a    = a;
        operand_b    = b;
        tgl          = ~tgl;
        ctrl_in[2:1] = op;
        ctrl_in[0]   = tgl;
        push_exp(a, b, op, k);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        bit   got = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < 100 && !got; i++) begin
                if (status[15:8] == e.cnt && !status[0]) got = 1'b1;
                else tick();
            end
            chk({tag, "_timeout"}, 64'(got), 1);
            chk({tag, "_latency"}, 64'(cyc), 64'(e.k + e.lat));
            chk({tag, "_hi"}, 64'(result_hi), 64'(e.hi));
            chk({tag, "_lo"}, 64'(result_lo), 64'(e.lo));
            chk({tag, "_dbz"}, 64'(status[2]), 64'(e.dbz));
            chk({tag, "_ill"}, 64'(status[3]), 64'(e.ill));
            chk({tag, "_done_tgl"}, 64'(status[1]), 64'(e.done));
            chk({tag, "_cnt"}, 64'(status[15:8]), 64'(e.cnt));
            chk({tag, "_upper0"}, 64'(status[31:16]), 0);
            chk({tag, "_rsvd0"}, 64'(status[7:5]), 0);
        end
    endtask

    initial begin
        int k;
        reset     = 1'b1;
        ctrl_in   = 8'h00;
        operand_a = '0;
        operand_b = '0;
        tick();
        tick();
        chk("rst_hi", 64'(result_hi), 0);
        chk("rst_lo", 64'(result_lo), 0);
        chk("rst_status", 64'(status), 0);
`ifdef COPROC_ENGINE_IRQ_EN
        chk("rst_irq", 64'(irq), 0);
`endif
        reset = 1'b0;
        tick();
        chk("idle_no_start", 64'(status), 0);

        // MULU max, busy visible right after edge k
        k = cyc + 1;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, k);
        tick();
        chk("mul_busy_k", 64'(status[0]), 1);
        repeat (31) tick();
        chk("mul_busy_k32", 64'(status[0]), 1);
        wait_done("mul_max");
`ifdef COPROC_ENGINE_IRQ_EN
        chk("irq_set", 64'(irq), 1);
        ctrl_in[7] = 1'b1;
        tick();
        chk("irq_ack", 64'(irq), 0);
        ctrl_in[7] = 1'b0;
`endif

        // Divide by zero, then a valid divide must clear the flag
        tick();
        start_op(32'h1234_5678, 32'h0, 2'b01, cyc + 1);
        wait_done("div0");
        tick();
        start_op(32'd100, 32'd7, 2'b01, cyc + 1);
        wait_done("divu");

        // Illegal opcodes
        tick();
        start_op(32'hDEAD_BEEF, 32'h5, 2'b10, cyc + 1);
        wait_done("ill10");
        tick();
        start_op(32'h1, 32'h1, 2'b11, cyc + 1);
        wait_done("ill11");

        // Two toggles during one op cancel out but leave overrun set
        chk("ovr_clear", 64'(status[4]), 0);
        tick();
        start_op(32'd2, 32'd3, 2'b00, cyc + 1);
        repeat (4) tick();
        ctrl_in[0] = ~tgl;
        repeat (3) tick();
        chk("ovr_set_dbl", 64'(status[4]), 1);
        ctrl_in[0] = tgl;
        wait_done("dbl_tgl");
        cnt_snap = status[15:8];
        repeat (4) tick();
        chk("dbl_no_start_busy", 64'(status[0]), 0);
        chk("dbl_no_start_cnt", 64'(status[15:8]), 64'(cnt_snap));

        // Overrun: second toggle at k+10 runs after the first op completes
        k = cyc + 1;
        start_op(32'd3, 32'd5, 2'b00, k);
        repeat (10) tick();
        start_op(32'd6, 32'd7, 2'b00, k + 34);
        tick();
        chk("ovr_k10", 64'(status[4]), 1);
        wait_done("ovr_first");
        tick();
        chk("ovr_second_busy", 64'(status[0]), 1);
        wait_done("ovr_second");
        chk("ovr_sticky", 64'(status[4]), 1);

        // Random MULU/DIVU
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = (i % 3 == 2) ? 32'($urandom_range(1, 255)) : $urandom();
            if (rb == 0) rb = 32'd1;
            tick();
            start_op(ra, rb, (i % 2 == 1) ? 2'b01 : 2'b00, cyc + 1);
            wait_done("rand");
        end

        // Op count wraps 255 -> 0
        while (status[15:8] != 8'd250) begin
            tick();
            start_op(32'h0, 32'h0, 2'b10, cyc + 1);
            wait_done("wrap_fill");
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            start_op(32'h0, 32'h0, 2'b10, cyc + 1);
            wait_done("wrap");
        end
        chk("wrap_cnt", 64'(status[15:8]), 2);

        // Reset mid-op with ctrl_in[0]=1 held through reset
        if (tgl) begin
            tick();
            start_op(32'h0, 32'h0, 2'b10, cyc + 1);
            wait_done("pre_rst");
        end
        tick();
        k = cyc + 1;
        start_op(32'd3, 32'd5, 2'b00, k);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        chk("midrst_hi", 64'(result_hi), 0);
        chk("midrst_lo", 64'(result_lo), 0);
        chk("midrst_status", 64'(status), 0);
`ifdef COPROC_ENGINE_IRQ_EN
        chk("midrst_irq", 64'(irq), 0);
`endif
        sb.delete();
        model_cnt = 8'd0;
        reset = 1'b0;
        k = cyc + 1;
        push_exp(32'd3, 32'd5, 2'b00, k);
        tick();
        chk("post_rst_busy", 64'(status[0]), 1);
        wait_done("post_rst");
`ifdef COPROC_ENGINE_IRQ_EN
        chk("post_rst_irq", 64'(irq), 1);
        ctrl_in[7] = 1'b1;
        tick();
        chk("post_rst_irq_ack", 64'(irq), 0);
        ctrl_in[7] = 1'b0;
`endif
        chk("sb_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
